// File: rtl/pkg_amba3.sv
// Shared AXI3 types plus the burst address-step helper used by the write slave
// and the future read slave.
package pkg_amba3;

  typedef enum logic [1:0] {
    FIXED      = 2'b00,
    INCR       = 2'b01,
    WRAP       = 2'b10,
    BURST_RSVD = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_type_e;

  typedef enum logic [1:0] {
    NORMAL    = 2'b00,
    EXCLUSIVE = 2'b01,
    LOCKED    = 2'b10,
    LOCK_RSVD = 2'b11
  } lock_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_e;

  // WRAP keeps the bits above the (len+1)*bytes window and wraps the bits inside it.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [3:0]  len,
                                                input burst_type_e burst);
    logic [63:0] bytes;
    logic [63:0] mask;
    bytes = 64'd1 << size;
    mask  = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      INCR:    axi_next_addr = addr + bytes;
      WRAP:    axi_next_addr = (addr & ~mask) | ((addr + bytes) & mask);
      default: axi_next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/amba3_axi_wr_slave_addr_gen.sv
// Burst address register: loads the start address, then steps once per
// accepted beat using axi_next_addr.
module amba3_axi_addr_gen
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_addr,
  input  logic                 advance,
  input  logic [2:0]           size,
  input  logic [3:0]           len,
  input  burst_type_e          burst,
  output logic [ADDR_SIZE-1:0] cur_addr
);

  logic [ADDR_SIZE-1:0] cur_addr_q;
  logic [ADDR_SIZE-1:0] cur_addr_d;

  always_comb begin
    cur_addr_d = cur_addr_q;
    if (load) begin
      cur_addr_d = load_addr;
    end else if (advance) begin
      cur_addr_d = ADDR_SIZE'(axi_next_addr(64'(cur_addr_q), size, len, burst));
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cur_addr_q <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
    end
  end

  assign cur_addr = cur_addr_q;

endmodule

// File: rtl/amba3_axi_wr_slave.sv
// AXI3 write-path slave: one outstanding burst, count-terminated, driving a
// word-wide memory write port. Optional macro: AMBA3_AXI_WR_SLAVE_DECERR_EN.
module amba3_axi_wr_slave
  import pkg_amba3::*;
#(
  parameter int AXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int STRB_SIZE = DATA_SIZE / 8,
  localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [AXID_SIZE-1:0] awid,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [3:0]           awlen,
  input  logic [2:0]           awsize,
  input  burst_type_e          awburst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [AXID_SIZE-1:0] wid,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [STRB_SIZE-1:0] wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [AXID_SIZE-1:0] bid,
  output resp_type_e           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic [STRB_SIZE-1:0] mem_wstrb
);

  localparam int LSB = $clog2(STRB_SIZE);

  wr_state_e            state_q, state_d;
  logic [AXID_SIZE-1:0] id_q, id_d;
  logic [3:0]           len_q, len_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [2:0]           size_q, size_d;
  burst_type_e          burst_q, burst_d;
  logic                 err_q, err_d;
  logic                 dec_q, dec_d;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 aw_err;
  logic                 aw_unaligned;
  logic                 last_beat;
  logic                 beat_err;
  logic                 dec_beat;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic                 addr_unused;

  assign awready = (state_q == IDLE);
  assign wready  = (state_q == DATA);
  assign bvalid  = (state_q == RESP);
  assign bid     = id_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign aw_unaligned = (64'(awaddr) & ((64'd1 << awsize) - 64'd1)) != 64'd0;
  assign aw_err = (awsize > 3'(LSB))
               || (awburst == BURST_RSVD)
               || ((awburst == WRAP) && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}))
               || ((awburst == WRAP) && aw_unaligned);

  // wlast must be high exactly on the counted final beat; mismatches poison the rest.
  assign last_beat = (beat_cnt_q == len_q);
  assign beat_err  = (wid != id_q) || (wlast != last_beat);

`ifdef AMBA3_AXI_WR_SLAVE_DECERR_EN
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_SIZE);
  assign dec_beat = (64'(cur_addr) >= MEM_BYTES);
`else
  assign dec_beat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    dec_d      = dec_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d       = awid;
          len_d      = awlen;
          size_d     = awsize;
          burst_d    = awburst;
          beat_cnt_d = 4'd0;
          err_d      = aw_err;
          dec_d      = 1'b0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          err_d      = err_q || beat_err;
          dec_d      = dec_q || dec_beat;
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bresp = OKAY;
    if (state_q == RESP) begin
      if (dec_q) begin
        bresp = DECERR;
      end else if (err_q) begin
        bresp = SLVERR;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= FIXED;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      dec_q      <= dec_d;
    end
  end

  amba3_axi_addr_gen #(
    .ADDR_SIZE(ADDR_SIZE)
  ) u_addr_gen (
    .aclk     (aclk),
    .areset_n (areset_n),
    .load     (aw_hs),
    .load_addr(awaddr),
    .advance  (w_hs),
    .size     (size_q),
    .len      (len_q),
    .burst    (burst_q),
    .cur_addr (cur_addr)
  );

  // Without decode checking the address bits above the memory window alias.
  assign addr_unused = ^cur_addr;

  assign mem_we    = w_hs && !(err_q || beat_err) && !dec_beat;
  assign mem_addr  = cur_addr[MEM_AW+LSB-1:LSB];
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

endmodule

// File: doc/amba3_axi_wr_slave.md
Name: amba3_axi_wr_slave

Overview:
AXI3 write-path responder (slave end). It accepts a write-address burst, consumes the write-data beats, and drives a simple synchronous word-wide memory write port. It then returns one write response per burst. Bus-facing ports attach to the slave side of amba3_axi_if; the memory port feeds an SRAM model or RTL register file.

Parameters:
AXID_SIZE, 4, ID width of awid/wid/bid
ADDR_SIZE, 32, byte address width
DATA_SIZE, 32, data bus width in bits (power of 2, >= 8); STRB_SIZE = DATA_SIZE/8
MEM_DEPTH, 1024, memory words; MEM_AW = $clog2(MEM_DEPTH)

Ports:
aclk  in  1  clock, all logic on rising edge
areset_n  in  1  asynchronous active-low reset
awid  in  AXID_SIZE  write address ID
awaddr  in  ADDR_SIZE  burst start byte address
awlen  in  4  beats minus one
awsize  in  3  log2 bytes per beat
awburst  in  burst_type_e  FIXED/INCR/WRAP
awvalid  in  1  address valid
awready  out  1  address accepted
wid  in  AXID_SIZE  write data ID
wdata  in  DATA_SIZE  write data
wstrb  in  STRB_SIZE  byte strobes
wlast  in  1  last beat flag
wvalid  in  1  data valid
wready  out  1  data accepted
bid  out  AXID_SIZE  response ID
bresp  out  resp_type_e  response
bvalid  out  1  response valid
bready  in  1  response accepted
mem_we  out  1  memory write strobe
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_SIZE  memory write data
mem_wstrb  out  STRB_SIZE  memory byte enables

Behaviour:
- Reset values: awready=1, wready=0, bvalid=0, bid=0, bresp=OKAY. mem_we=0 while in reset; all internal registers cleared. Async reset mid-burst drops the burst immediately; the FSM returns to IDLE and no response is issued.
- FSM states and transitions:
  - IDLE: awready=1. awvalid&&awready latches id/addr/len/size/burst, clears beat_cnt and err, then goes to DATA.
  - DATA: awready=0, wready=1. Each wvalid&&wready is one beat. The beat with beat_cnt==len goes to RESP.
  - RESP: wready=0, bvalid=1, bid=latched id. bvalid&&bready goes to IDLE with awready=1 in the next cycle. Minimum burst cost is len+3 cycles.
- Single outstanding burst. Burst termination is count-based; wlast is checked but does not terminate the burst.
- mem_we = wvalid && wready && !err_next, combinational from the beat handshake (zero latency). The other memory outputs follow the same beat:
  - mem_addr = cur_addr[MEM_AW+log2(STRB_SIZE)-1 : log2(STRB_SIZE)]
  - mem_wdata = wdata
  - mem_wstrb = wstrb, passed unmodified
- Address update after each beat (bytes = 1<<size):
  - FIXED: cur_addr unchanged.
  - INCR: cur_addr += bytes, modulo 2^ADDR_SIZE.
  - WRAP: boundary = (len+1)*bytes. The low bits wrap within an aligned window of that size; high bits are held.
- SLVERR conditions (err is sticky for the rest of the burst):
  - awsize > log2(STRB_SIZE)
  - WRAP with len not in {1,3,7,15}
  - WRAP with awaddr unaligned to bytes
  - burst type 2'b11
  - wid != latched id on any beat
  - wlast mismatch on any beat (wlast set early, or clear on the final beat)
- Error handling:
  - awsize, WRAP and burst-type errors are flagged at AW accept; no memory writes occur for that burst.
  - wid and wlast errors suppress the failing beat and all later beats. Earlier beats stay written.
  - All beats are still accepted, then bresp=SLVERR.
- Otherwise bresp=OKAY. bresp/bid are held stable while bvalid && !bready.
- Same-cycle events: awvalid during DATA/RESP is stalled (awready=0). wvalid in IDLE/RESP is stalled (wready=0).

Optional Feature:
AMBA3_AXI_WR_SLAVE_DECERR_EN
- Defined: any beat whose byte address >= MEM_DEPTH*STRB_SIZE has mem_we suppressed and sets a sticky decode error. A decode error gives bresp=DECERR, which takes priority over SLVERR.
- Undefined: address bits above mem_addr are ignored (aliasing), and DECERR is never generated.

Decomposition:
- Package pkg_amba3 holds the existing burst_type_e, resp_type_e and lock_type_e, plus new items:
  - state enum wr_state_e {IDLE, DATA, RESP}
  - function axi_next_addr(addr, size, len, burst), pure combinational
- One sub-module, amba3_axi_addr_gen: registered cur_addr with load/advance inputs, built on axi_next_addr. It is reused by the future read slave.

Test Plan:
- INCR awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, wstrb=0xF -> mem_we 4 beats at mem_addr 4,5,6,7; bid=awid; bresp=OKAY.
- WRAP awaddr=0x38, awlen=3, awsize=2 -> mem_addr 14,15,12,13; bresp=OKAY.
- FIXED awaddr=0x20, awlen=2 -> mem_addr 8 three times; bready held low 5 cycles -> bvalid/bid/bresp stable, awready=0 until accepted.
- awlen=3 with wlast asserted on beat 1 -> beat 0 written, beats 1..3 suppressed, 4 beats accepted, bresp=SLVERR; awsize=3 on 32-bit bus -> no mem_we, bresp=SLVERR.
- areset_n pulsed low during beat 2 of awlen=7 -> next cycle wready=0, bvalid=0, awready=1; a new INCR burst then completes with OKAY.
- DECERR_EN defined, awaddr=MEM_DEPTH*4, awlen=0 -> mem_we=0, bresp=DECERR. Undefined -> mem_addr=0 written, bresp=OKAY.
